// File: rtl/round_sequencer_pkg.sv
// Shared types and constants for the round sequencer and its LFSR.
package round_sequencer_pkg;

  // FSM states; the encoding is exported on the debug LEDs.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COUNT = 3'd2,
    GEN   = 3'd3,
    SHOW  = 3'd4,
    INPUT = 3'd5,
    PASS  = 3'd6,
    FAIL  = 3'd7
  } state_t;

  // One game symbol (button code).
  typedef logic [1:0] symbol_t;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR step: shift left, feed the tap parity into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/round_sequencer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with synchronous reset to a seed.
module lfsr16
  import round_sequencer_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  // Advance every cycle outside reset so player timing stirs the sequence.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (reset) state <= SEED;
    else       state <= lfsr_step(state);
  end

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: arms the countdown, generates and presents a
// pseudo-random symbol sequence, judges the player's entries, owns the level.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int          MAX_LEVEL   = 9,
  parameter int          SEQ_BASE    = 2,
  parameter int          SHOW_TICKS  = 50_000_000,
  parameter int          GAP_TICKS   = 25_000_000,
  parameter int          INPUT_TICKS = 500_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       StartBtn,
  input  logic       DoneCounting,
  input  logic       BtnValid,
  input  logic [1:0] BtnCode,
  output logic       Start,
  output logic [3:0] CurLevel,
  output logic       ShowValid,
  output logic [1:0] ShowSymbol,
  output logic       Win,
  output logic       Lose,
  output logic [2:0] StateDbg
);

  localparam int SEQ_DEPTH = MAX_LEVEL + SEQ_BASE;
  localparam int IDX_W     = $clog2(SEQ_DEPTH);
  localparam int TICK_MAX  = (SHOW_TICKS > GAP_TICKS)
                           ? ((SHOW_TICKS > INPUT_TICKS) ? SHOW_TICKS : INPUT_TICKS)
                           : ((GAP_TICKS > INPUT_TICKS) ? GAP_TICKS : INPUT_TICKS);
  localparam int TICK_W    = $clog2(TICK_MAX + 1);

  localparam logic [TICK_W-1:0] SHOW_LAST  = TICK_W'(SHOW_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST   = TICK_W'(GAP_TICKS - 1);
  localparam logic [TICK_W-1:0] INPUT_LAST = TICK_W'(INPUT_TICKS - 1);
  localparam logic [3:0]        LEVEL_TOP  = 4'(MAX_LEVEL);

  state_t            state_q, state_d;
  logic [3:0]        level_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TICK_W-1:0] tick_q;
  logic              showing_q;   // 1: symbol on display, 0: blank gap
  logic              start_req_q; // StartBtn registered while IDLE
  logic              win_q, lose_q;
  logic [15:0]       lfsr_state;
  symbol_t           seq_buf [SEQ_DEPTH];

  logic [IDX_W-1:0]  last_idx;
  logic              last_entry, btn_match;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (Clk100M),
    .reset (Reset),
    .state (lfsr_state)
  );

  assign last_idx   = IDX_W'(level_q) + IDX_W'(SEQ_BASE - 1);
  assign last_entry = (idx_q == last_idx);
  assign btn_match  = (BtnCode == seq_buf[idx_q]);

  // State register.
  always_ff @(posedge Clk100M) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_req_q) state_d = ARM;
      ARM:   state_d = COUNT;
      COUNT: if (DoneCounting) state_d = GEN;
      GEN:   if (last_entry) state_d = SHOW;
      SHOW:  if (!showing_q && tick_q == GAP_LAST && last_entry) state_d = INPUT;
      INPUT: begin
        // A button press wins over a timeout expiring in the same cycle.
        if (BtnValid) begin
          if (!btn_match)     state_d = FAIL;
          else if (last_entry) state_d = PASS;
        end else if (tick_q == INPUT_LAST) begin
          state_d = FAIL;
        end
      end
      PASS:    state_d = (level_q == LEVEL_TOP) ? IDLE : ARM;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Level, index, tick counters and result pulses.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      level_q     <= 4'd1;
      idx_q       <= '0;
      tick_q      <= '0;
      showing_q   <= 1'b0;
      start_req_q <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      // The input register gives StartBtn -> Start a fixed two-cycle latency.
      start_req_q <= StartBtn && (state_q == IDLE);
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      case (state_q)
        ARM, COUNT: begin
          idx_q  <= '0;
          tick_q <= '0;
        end
        GEN: begin
          if (last_entry) begin
            idx_q     <= '0;
            tick_q    <= '0;
            showing_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SHOW: begin
          if (showing_q) begin
            if (tick_q == SHOW_LAST) begin
              showing_q <= 1'b0;
              tick_q    <= '0;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end else if (tick_q == GAP_LAST) begin
            tick_q    <= '0;
            showing_q <= !last_entry;
            idx_q     <= last_entry ? '0 : idx_q + 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        INPUT: begin
          if (BtnValid) begin
            tick_q <= '0;
            if (btn_match && !last_entry) idx_q <= idx_q + 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        PASS: begin
          if (level_q == LEVEL_TOP) begin
            level_q <= 4'd1;
            win_q   <= 1'b1;
          end else begin
            level_q <= level_q + 4'd1;
          end
        end
        FAIL: begin
          level_q <= 4'd1;
          lose_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequence buffer write during GEN.
  always_ff @(posedge Clk100M) begin
    // NOTE: the buffer is deliberately not reset; every entry read is written
    // in GEN first, and leaving it out of reset keeps it a plain RAM.
    if (!Reset && state_q == GEN) seq_buf[idx_q] <= lfsr_state[1:0];
  end

  assign Start      = (state_q == ARM);
  assign CurLevel   = level_q;
  assign ShowValid  = (state_q == SHOW) && showing_q;
  assign ShowSymbol = ShowValid ? seq_buf[idx_q] : 2'd0;
  assign Win        = win_q;
  assign Lose       = lose_q;
  assign StateDbg   = state_q;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-round controller that sits directly upstream of the countdown-timer stage.
- Owns the current level (1..MAX_LEVEL) and issues the one-cycle start pulse to the countdown. It waits for the countdown's done pulse, then generates and plays a pseudo-random symbol sequence, collects player button entries and judges pass/fail.
- On a pass it advances the level, which is fed back to the countdown's level input.

Parameters:
MAX_LEVEL, 9, highest level; must be 1..9 so the countdown stage can show it on one seven-segment digit
SEQ_BASE, 2, sequence length = CurLevel + SEQ_BASE
SHOW_TICKS, 50_000_000, Clk100M cycles each symbol is presented
GAP_TICKS, 25_000_000, blank cycles between presented symbols
INPUT_TICKS, 500_000_000, max cycles allowed between player entries before timeout
LFSR_SEED, 16'hACE1, reset value of the sequence LFSR; must be non-zero

Ports:
Clk100M  in  1  system clock; the only clock
Reset  in  1  synchronous, active-high reset
StartBtn  in  1  debounced one-cycle pulse: begin or continue a game
DoneCounting  in  1  one-cycle pulse from the countdown stage
BtnValid  in  1  one-cycle pulse: player entered a symbol
BtnCode  in  2  symbol entered, sampled when BtnValid=1
Start  out  1  one-cycle pulse to the countdown stage
CurLevel  out  4  current level, 1..MAX_LEVEL
ShowValid  out  1  high while a symbol is being presented
ShowSymbol  out  2  presented symbol; 0 when ShowValid=0
Win  out  1  one-cycle pulse: MAX_LEVEL passed
Lose  out  1  one-cycle pulse: wrong entry or timeout
StateDbg  out  3  state encoding, for debug LEDs

Behaviour:
- Reset values:
  - Outputs: Start=0, CurLevel=1, ShowValid=0, ShowSymbol=0, Win=0, Lose=0, StateDbg=IDLE.
  - Internals: LFSR=LFSR_SEED, all counters and indices 0.
  - Reset mid-operation aborts the round immediately; no Win or Lose pulse is emitted.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle outside reset, so player timing adds entropy.
- Sequence buffer: (MAX_LEVEL+SEQ_BASE) x 2 bits.
- States and transitions:
  - IDLE: on StartBtn -> ARM.
  - ARM: Start=1 for exactly this one cycle -> COUNT.
  - COUNT: wait for DoneCounting -> GEN. No timeout.
  - GEN: writes LFSR[1:0] into buffer entry idx, one entry per cycle, for idx 0..len-1, where len=CurLevel+SEQ_BASE. Lasts len cycles -> SHOW.
  - SHOW: for each entry, ShowValid=1 and ShowSymbol=entry for SHOW_TICKS cycles, then blank for GAP_TICKS cycles. After the last gap -> INPUT with idx=0 and the timeout counter cleared.
  - INPUT:
    - On BtnValid, compare BtnCode with entry idx.
    - Mismatch -> FAIL.
    - Match and idx=len-1 -> PASS.
    - Otherwise idx+1 and the timeout counter is cleared.
    - Timeout counter reaching INPUT_TICKS -> FAIL.
  - PASS:
    - If CurLevel=MAX_LEVEL: Win=1 for one cycle, CurLevel<=1 -> IDLE.
    - Else: CurLevel+1 -> ARM, so the next countdown starts automatically.
  - FAIL: Lose=1 for one cycle, CurLevel<=1 -> IDLE.
- CurLevel changes only in PASS, FAIL or reset. It is stable from ARM through INPUT, so the countdown reads a steady level.
- Ignored inputs:
  - DoneCounting outside COUNT.
  - BtnValid outside INPUT.
  - StartBtn outside IDLE.
- Simultaneous BtnValid and timeout expiry in the same cycle: the button is evaluated and the timeout is discarded.
- Latency:
  - StartBtn to Start: 2 cycles.
  - DoneCounting to first ShowValid: len+1 cycles.
  - Final correct BtnValid to Win/Lose or next Start: 2 cycles.
- Tick counters must be wide enough for max(SHOW_TICKS, GAP_TICKS, INPUT_TICKS). Each reloads at zero on entry to its phase.

Decomposition:
- Shared package:
  - State enum: IDLE=0, ARM=1, COUNT=2, GEN=3, SHOW=4, INPUT=5, PASS=6, FAIL=7.
  - 2-bit symbol type.
  - LFSR tap constant.
- One sub-module: lfsr16. Free-running, synchronous reset to seed, exposes its 16-bit state.

Test Plan:
- Parameters for the bench: SHOW_TICKS=4, GAP_TICKS=2, INPUT_TICKS=20.
- Reset then StartBtn -> Start pulses exactly once, 2 cycles later. CurLevel=1. No ShowValid until DoneCounting is driven.
- Level 1 with DoneCounting pulsed -> 3 symbols shown, each ShowValid high for 4 cycles with 2-cycle gaps. Enter the 3 shown codes -> Start re-pulses and CurLevel=2.
- In INPUT, enter a wrong code on the 2nd symbol -> Lose pulse 1 cycle, CurLevel=1, StateDbg=0.
- In INPUT, no BtnValid for 20 cycles -> Lose. Repeat with BtnValid (correct code) on the expiry cycle -> no Lose, idx advances.
- Force CurLevel=9 and pass all 11 symbols -> Win pulse 1 cycle, CurLevel=1, IDLE. Stray DoneCounting/BtnValid pulses in IDLE -> no state change.
- Assert Reset during SHOW -> next cycle ShowValid=0, CurLevel=1, IDLE, no Lose/Win. LFSR equals LFSR_SEED after reset.
